// File: rtl/fun_fpusqr_wbq.sv
// fun_fpusqr_wbq: writeback queue behind the FP divide/sqrt unit.
// Each result announcement (II, op, reg) is carried down a DATA_LAT-deep tag
// pipe. When it reaches the last stage, it is paired with the alt_data beat
// and pushed into a DEPTH-entry FIFO. The FIFO drains one entry per cycle
// into the FP writeback port whenever the main pipe leaves the slot free.
//
// Optional feature macro: FUN_FPUSQR_WBQ_BYPASS_EN
//   When defined, a result that finds the FIFO empty and the slot free goes
//   straight to the wb_* registers and skips the FIFO.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   except            flush: drop every queued and in-flight result
//   alt_en/II/op/reg  result announcement from the divider
//   alt_data          result data, DATA_LAT cycles after alt_en
//   wb_slot_free      main FP pipe is not writing back this cycle
//   wb_en/II/op/reg/data  registered writeback of the FIFO head
//   pause             combinational back-pressure to the divider retire logic
//   ovf_err           sticky: an announcement arrived with no credit left
module fun_fpusqr_wbq #(
    parameter bit           H        = 1'b0,
    parameter int unsigned  DEPTH    = 4,
    parameter int unsigned  DATA_LAT = 5,
    localparam int unsigned DW       = (H ? 32'd16 : 32'd0) + 32'd68
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          except,
    input  logic          alt_en,
    input  logic [9:0]    alt_II,
    input  logic [12:0]   alt_op,
    input  logic [8:0]    alt_reg,
    input  logic [DW-1:0] alt_data,
    input  logic          wb_slot_free,
    output logic          wb_en,
    output logic [9:0]    wb_II,
    output logic [12:0]   wb_op,
    output logic [8:0]    wb_reg,
    output logic [DW-1:0] wb_data,
    output logic          pause,
    output logic          ovf_err
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned OW   = $clog2(DEPTH + DATA_LAT) + 1;
    localparam int unsigned TW   = 32;
    localparam int unsigned EW   = TW + DW;
    localparam int unsigned LAST = DATA_LAT - 1;

    logic          tagVld  [DATA_LAT];
    logic [TW-1:0] tagInfo [DATA_LAT];
    logic [EW-1:0] mem     [DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [CW-1:0] count;
    logic [OW-1:0] inflight;
    logic [OW-1:0] occ;
    logic          noCredit;
    logic          accept;
    logic          doPush;
    logic          doPop;
    logic          doBypass;
    logic [EW-1:0] headEntry;

    // Number of announcements still travelling down the tag pipe.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < DATA_LAT; i++) begin
            inflight = inflight + OW'(tagVld[i]);
        end
    end

    // Credit accounting covers both queued and in-flight results, so a
    // pause raised one entry early leaves room for the announce already
    // on its way.
    assign occ      = OW'(count) + inflight;
    assign noCredit = occ >= OW'(DEPTH);
    assign pause    = (occ >= OW'(DEPTH - 1)) | except;
    assign accept   = alt_en & ~except & ~noCredit;
    assign doPop    = wb_slot_free & (count != '0);

`ifdef FUN_FPUSQR_WBQ_BYPASS_EN
    assign doBypass = tagVld[LAST] & (count == '0) & wb_slot_free;
`else
    assign doBypass = 1'b0;
`endif

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush    = tagVld[LAST] & ~doBypass & ((count != CW'(DEPTH)) | doPop);
    assign headEntry = mem[rdPtr];

    // Tag pipe: stage 0 takes the accepted announcement, flush kills all valids.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DATA_LAT; i++) begin
                tagVld[i]  <= 1'b0;
                tagInfo[i] <= '0;
            end
        end else begin
            tagVld[0]  <= accept;
            tagInfo[0] <= {alt_II, alt_op, alt_reg};
            for (int i = 1; i < DATA_LAT; i++) begin
                tagVld[i]  <= tagVld[i-1] & ~except;
                tagInfo[i] <= tagInfo[i-1];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (except) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: tag fields from the last stage paired with the data beat.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= {tagInfo[LAST], alt_data};
    end

    // Sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
        end else if (alt_en & noCredit) begin
            ovf_err <= 1'b1;
        end
    end

    // Writeback register: head of FIFO, bypassed result, or all zeros.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_en <= 1'b0;
            {wb_II, wb_op, wb_reg, wb_data} <= '0;
        end else if (except) begin
            wb_en <= 1'b0;
            {wb_II, wb_op, wb_reg, wb_data} <= '0;
        end else if (doPop) begin
            wb_en <= 1'b1;
            {wb_II, wb_op, wb_reg, wb_data} <= headEntry;
        end else if (doBypass) begin
            wb_en <= 1'b1;
            {wb_II, wb_op, wb_reg, wb_data} <= {tagInfo[LAST], alt_data};
        end else begin
            wb_en <= 1'b0;
            {wb_II, wb_op, wb_reg, wb_data} <= '0;
        end
    end

endmodule

// File: tb/tb_fun_fpusqr_wbq.sv
// tb_fun_fpusqr_wbq: randomized scoreboard bench for fun_fpusqr_wbq.
// The reference model tracks accepted-but-not-written-back results as an
// ordered list with their announce cycle; the oldest one may leave once its
// data has had time to arrive and the slot is free.
module tb_fun_fpusqr_wbq;

    localparam int DEPTH    = 4;
    localparam int DATA_LAT = 5;
    localparam int DW       = 68;
    localparam int BIG      = 32'h3fff_ffff;
`ifdef FUN_FPUSQR_WBQ_BYPASS_EN
    localparam int ELIG = DATA_LAT;
`else
    localparam int ELIG = DATA_LAT + 1;
`endif

    typedef struct {
        logic [9:0]    ii;
        logic [12:0]   op;
        logic [8:0]    rg;
        logic [DW-1:0] d;
        int            t;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          except;
    logic          alt_en;
    logic [9:0]    alt_II;
    logic [12:0]   alt_op;
    logic [8:0]    alt_reg;
    logic [DW-1:0] alt_data;
    logic          wb_slot_free;
    logic          wb_en;
    logic [9:0]    wb_II;
    logic [12:0]   wb_op;
    logic [8:0]    wb_reg;
    logic [DW-1:0] wb_data;
    logic          pause;
    logic          ovf_err;

    fun_fpusqr_wbq #(.H(1'b0), .DEPTH(DEPTH), .DATA_LAT(DATA_LAT)) dut (
        .clk(clk), .rst(rst), .except(except),
        .alt_en(alt_en), .alt_II(alt_II), .alt_op(alt_op), .alt_reg(alt_reg),
        .alt_data(alt_data), .wb_slot_free(wb_slot_free),
        .wb_en(wb_en), .wb_II(wb_II), .wb_op(wb_op), .wb_reg(wb_reg),
        .wb_data(wb_data), .pause(pause), .ovf_err(ovf_err)
    );

    int            nChk = 0;
    int            nFail = 0;
    int            cyc = 0;
    int            wbCount = 0;
    int            ovfFrom = BIG;
    bit            pauseExp = 1'b0;
    ent_t          mdl[$];
    ent_t          outQ[$];
    logic [DW-1:0] beats[int];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string name,
                                input logic [127:0] act, input logic [127:0] exp);
        nChk++;
        if (!ok) begin
            nFail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] rndData();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // One clock cycle of stimulus plus the reference model's view of it.
    task automatic step(input bit en, input logic [9:0] ii, input logic [12:0] op,
                        input logic [8:0] rg, input logic [DW-1:0] d,
                        input bit slot, input bit exc);
        ent_t e;
        int   c;
        int   occ;
        @(posedge clk);
        #1;
        c = cyc;
        alt_en = en; alt_II = ii; alt_op = op; alt_reg = rg;
        wb_slot_free = slot; except = exc;
        alt_data = beats.exists(c) ? beats[c] : rndData();
        occ = mdl.size();
        pauseExp = (occ >= DEPTH - 1) || exc;
        if (en && occ >= DEPTH && c + 1 < ovfFrom) ovfFrom = c + 1;
        if (exc) begin
            mdl.delete();
        end else begin
            if (slot && mdl.size() != 0 && c >= mdl[0].t + ELIG) begin
                e = mdl.pop_front();
                e.t = c + 1;
                outQ.push_back(e);
            end
            if (en && occ < DEPTH) begin
                e.ii = ii; e.op = op; e.rg = rg; e.d = d; e.t = c;
                mdl.push_back(e);
                beats[c + DATA_LAT] = d;
            end
        end
    endtask

    task automatic idle(input int n, input bit slot);
        for (int i = 0; i < n; i++) step(1'b0, 10'd0, 13'd0, 9'd0, '0, slot, 1'b0);
    endtask

    task automatic ann(input logic [9:0] ii, input bit slot);
        step(1'b1, ii, 13'($urandom), 9'($urandom), rndData(), slot, 1'b0);
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard.
    always @(negedge clk) begin : monitor
        bit   expWb;
        ent_t e;
        if (rst) begin
            expWb = (outQ.size() != 0) && (outQ[0].t == cyc);
            chk(wb_en === expWb, "wb_en", 128'(wb_en), 128'(expWb));
            if (expWb) begin
                e = outQ.pop_front();
                if (wb_en === 1'b1)
                    chk({wb_II, wb_op, wb_reg, wb_data} === {e.ii, e.op, e.rg, e.d}, "wb_fields",
                        128'({wb_II, wb_op, wb_reg, wb_data}), 128'({e.ii, e.op, e.rg, e.d}));
            end else if (wb_en === 1'b0) begin
                chk({wb_II, wb_op, wb_reg, wb_data} === '0, "wb_idle_zero",
                    128'({wb_II, wb_op, wb_reg, wb_data}), 128'(0));
            end
            if (wb_en === 1'b1) wbCount++;
            chk(pause === pauseExp, "pause", 128'(pause), 128'(pauseExp));
            chk(ovf_err === (cyc >= ovfFrom), "ovf_err", 128'(ovf_err), 128'(cyc >= ovfFrom));
        end
    end

    initial begin : driver
        int base;
        int issued;
        int k;
        bit en;
        rst = 1'b0; except = 1'b0; alt_en = 1'b0; alt_II = '0; alt_op = '0;
        alt_reg = '0; alt_data = '0; wb_slot_free = 1'b0;
        repeat (3) @(negedge clk);
        chk(wb_en === 1'b0, "rst_wb_en", 128'(wb_en), 128'(0));
        chk({wb_II, wb_op, wb_reg, wb_data} === '0, "rst_wb_fields",
            128'({wb_II, wb_op, wb_reg, wb_data}), 128'(0));
        chk(pause === 1'b0, "rst_pause", 128'(pause), 128'(0));
        chk(ovf_err === 1'b0, "rst_ovf", 128'(ovf_err), 128'(0));
        @(posedge clk); #1 rst = 1'b1;

        // Single result with a free slot.
        base = wbCount;
        step(1'b1, 10'h005, 13'h0abc, 9'h01A, 68'h123, 1'b1, 1'b0);
        idle(10, 1'b1);
        chk(wbCount - base == 1, "single_count", 128'(wbCount - base), 128'(1));

        // Hold-off then release.
        base = wbCount;
        ann(10'd1, 1'b0); ann(10'd2, 1'b0); ann(10'd3, 1'b0);
        idle(8, 1'b0);
        idle(10, 1'b1);
        chk(wbCount - base == 3, "holdoff_count", 128'(wbCount - base), 128'(3));

        // Overflow: five back-to-back announces against a busy slot.
        base = wbCount;
        for (int i = 0; i < 5; i++) ann(10'(20 + i), 1'b0);
        idle(8, 1'b0);
        idle(12, 1'b1);
        chk(wbCount - base == 4, "ovf_count", 128'(wbCount - base), 128'(4));

        // Flush with two queued and one in the tag pipe.
        ann(10'd40, 1'b0); ann(10'd41, 1'b0);
        idle(DATA_LAT, 1'b0);
        ann(10'd42, 1'b0);
        step(1'b1, 10'd43, 13'd0, 9'd0, rndData(), 1'b0, 1'b1);
        base = wbCount;
        idle(14, 1'b1);
        chk(wbCount - base == 0, "flush_count", 128'(wbCount - base), 128'(0));

        // Wrap: slot toggles every cycle.
        base = wbCount;
        issued = 0;
        k = 0;
        while (issued < 10) begin
            en = mdl.size() < DEPTH - 1;
            step(en, 10'(100 + issued), 13'($urandom), 9'($urandom), rndData(), k[0], 1'b0);
            if (en) issued++;
            k++;
        end
        for (int i = 0; i < 30; i++) step(1'b0, 10'd0, 13'd0, 9'd0, '0, i[0], 1'b0);
        chk(wbCount - base == 10, "wrap_count", 128'(wbCount - base), 128'(10));

        // Asynchronous reset while results are queued.
        ann(10'd60, 1'b0); ann(10'd61, 1'b0); ann(10'd62, 1'b0);
        idle(DATA_LAT + 2, 1'b0);
        idle(1, 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk(wb_en === 1'b0, "arst_wb_en", 128'(wb_en), 128'(0));
        chk({wb_II, wb_op, wb_reg, wb_data} === '0, "arst_wb_fields",
            128'({wb_II, wb_op, wb_reg, wb_data}), 128'(0));
        chk(pause === 1'b0, "arst_pause", 128'(pause), 128'(0));
        chk(ovf_err === 1'b0, "arst_ovf", 128'(ovf_err), 128'(0));
        mdl.delete(); outQ.delete(); beats.delete(); ovfFrom = BIG;
        idle(3, 1'b1);
        rst = 1'b1;
        base = wbCount;
        idle(15, 1'b1);
        chk(wbCount - base == 0, "arst_count", 128'(wbCount - base), 128'(0));

        // Randomized traffic, occasionally ignoring pause or flushing.
        for (int i = 0; i < 500; i++) begin
            en = ($urandom_range(0, 1) == 1) &&
                 ((mdl.size() < DEPTH - 1) || ($urandom_range(0, 19) == 0));
            step(en, 10'($urandom), 13'($urandom), 9'($urandom), rndData(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
        end
        idle(30, 1'b1);
        chk(outQ.size() == 0, "drain_outq", 128'(outQ.size()), 128'(0));
        chk(mdl.size() == 0, "drain_model", 128'(mdl.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
